// File: rtl/si57x_freq_arbiter_pkg.sv
// ============================================================================
// si57x_pkg : widths, FSM states and setting-validity check for the arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package si57x_pkg;

  localparam int c_RFREQ_W = 38;
  localparam int c_N1_W    = 7;
  localparam int c_HS_W    = 3;

  // Bit h set means HS code h is a legal divider (codes 4 and 6 are not).
  localparam logic [7:0] c_HS_VALID_MASK = 8'b10101111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GUARD = 2'd2
  } state_t;

  function automatic logic setting_valid(input logic [c_N1_W-1:0] n1,
                                         input logic [c_HS_W-1:0] hs);
    return ((n1 == '0) || n1[0]) && c_HS_VALID_MASK[hs];
  endfunction

endpackage

`default_nettype wire

// File: rtl/si57x_freq_arbiter_rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational round-robin pick, searching from last+1 cyclically
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int g_NUM_REQ = 2
) (
  input  logic [g_NUM_REQ-1:0] req,
  input  logic [2:0]           last,
  output logic [2:0]           grant,
  output logic                 valid
);

  int k;

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    k     = 0;
    for (int i = g_NUM_REQ; i >= 1; i--) begin
      k = int'(last) + i;
      if (k >= g_NUM_REQ) k = k - g_NUM_REQ;
      if (req[k]) begin
        grant = 3'(k);
        valid = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/si57x_freq_arbiter.sv
// ============================================================================
// si57x_freq_arbiter : round-robin share of the Si57x ext_wr port with guard
// Rev 1.0
// ============================================================================
`default_nettype none

module si57x_freq_arbiter
  import si57x_pkg::*;
#(
  parameter int g_NUM_REQ      = 2,
  parameter int g_GUARD_CYCLES = 100000
) (
  input  logic                           clk_sys_i,
  input  logic                           rst_n_i,
  input  logic [g_NUM_REQ-1:0]           req_i,
  input  logic [c_RFREQ_W*g_NUM_REQ-1:0] req_rfreq_i,
  input  logic [c_N1_W*g_NUM_REQ-1:0]    req_n1_i,
  input  logic [c_HS_W*g_NUM_REQ-1:0]    req_hs_i,
  output logic [g_NUM_REQ-1:0]           ack_o,
  output logic [g_NUM_REQ-1:0]           err_o,
  output logic                           ext_wr_o,
  output logic [c_RFREQ_W-1:0]           ext_rfreq_value_o,
  output logic [c_N1_W-1:0]              ext_n1_value_o,
  output logic [c_HS_W-1:0]              ext_hs_value_o,
  output logic                           busy_o,
  output logic [2:0]                     grant_idx_o
);

  localparam int         c_CNT_W     = (g_GUARD_CYCLES > 1) ? $clog2(g_GUARD_CYCLES) : 1;
  localparam logic [2:0] c_LAST_INIT = 3'(g_NUM_REQ - 1);

  state_t               state;
  logic [c_CNT_W-1:0]   guard_cnt;
  logic                 pend_valid;
  logic [2:0]           win_idx;
  logic                 win_any;
  int                   sel;
  logic [c_RFREQ_W-1:0] win_rfreq;
  logic [c_N1_W-1:0]    win_n1;
  logic [c_HS_W-1:0]    win_hs;
  logic                 win_ok;

  rr_arbiter #(
    .g_NUM_REQ (g_NUM_REQ)
  ) u_rr (
    .req   (req_i),
    .last  (grant_idx_o),
    .grant (win_idx),
    .valid (win_any)
  );

  always_comb begin
    sel       = int'(win_idx);
    win_rfreq = req_rfreq_i[sel*c_RFREQ_W +: c_RFREQ_W];
    win_n1    = req_n1_i[sel*c_N1_W +: c_N1_W];
    win_hs    = req_hs_i[sel*c_HS_W +: c_HS_W];
    win_ok    = setting_valid(win_n1, win_hs);
  end

  // The ISSUE-cycle outputs are registered on the IDLE sampling edge, so they
  // are visible exactly during the single ISSUE cycle.
  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) begin
      state             <= IDLE;
      guard_cnt         <= '0;
      pend_valid        <= 1'b0;
      ack_o             <= '0;
      err_o             <= '0;
      ext_wr_o          <= 1'b0;
      ext_rfreq_value_o <= '0;
      ext_n1_value_o    <= '0;
      ext_hs_value_o    <= '0;
      busy_o            <= 1'b0;
      grant_idx_o       <= c_LAST_INIT;
    end else begin
      ack_o    <= '0;
      err_o    <= '0;
      ext_wr_o <= 1'b0;
      case (state)
        IDLE: begin
          if (win_any) begin
            grant_idx_o <= win_idx;
            ack_o       <= g_NUM_REQ'(1) << win_idx;
            pend_valid  <= win_ok;
            busy_o      <= 1'b1;
            state       <= ISSUE;
            if (win_ok) begin
              ext_wr_o          <= 1'b1;
              ext_rfreq_value_o <= win_rfreq;
              ext_n1_value_o    <= win_n1;
              ext_hs_value_o    <= win_hs;
            end else begin
              err_o <= g_NUM_REQ'(1) << win_idx;
            end
          end
        end
        ISSUE: begin
          guard_cnt <= c_CNT_W'(g_GUARD_CYCLES - 1);
          if (pend_valid) begin
            state <= GUARD;
          end else begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        GUARD: begin
          if (guard_cnt == '0) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            guard_cnt <= guard_cnt - 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
